// File: rtl/mem_access.sv
// mem_access: memory stage of the dual-lane 64-bit-bundle pipeline.
// Drives BRAM port b combinationally from the exec bundle (one-cycle read
// latency) and registers the bundle towards writeback so inst_to_wb lines up
// with mem_doutb. Bundles whose lanes hit different words are split over two
// cycles (upper lane first, then lower lane) with a one-cycle stall request.
// Optional build macro: MEM_ACCESS_PERF_EN adds saturating load/store/split
// counters on ports perf_load_cnt, perf_store_cnt and perf_split_cnt.
//
// Flow control: stall_req is combinational and asks exec to present the same
// bundle again on the next cycle; interlock is a global freeze that blocks
// any BRAM access and holds every register, so a frozen cycle is invisible.
module mem_access #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              interlock,
    input  logic [63:0]       inst_from_exec,
    input  logic [31:0]       u_addr_from_exec,
    input  logic [31:0]       u_sdata_from_exec,
    input  logic [4:0]        u_rt_from_exec,
    input  logic [31:0]       l_addr_from_exec,
    input  logic [31:0]       l_sdata_from_exec,
    input  logic [31:0]       l_tdata_from_exec,
    input  logic [4:0]        l_rt_from_exec,
    input  logic              l_rt_flag_from_exec,
    output logic [ADDR_W-1:0] mem_addrb,
    output logic [63:0]       mem_dinb,
    output logic [7:0]        mem_web,
    output logic              mem_enb,
    output logic [63:0]       inst_to_wb,
    output logic [4:0]        u_rt_to_wb,
    output logic              u_rt_flag_to_wb,
    output logic [31:0]       l_tdata_to_wb,
    output logic [4:0]        l_rt_to_wb,
    output logic              l_rt_flag_to_wb,
    output logic              stall_req,
`ifdef MEM_ACCESS_PERF_EN
    output logic [31:0]       perf_load_cnt,
    output logic [31:0]       perf_store_cnt,
    output logic [31:0]       perf_split_cnt,
`endif
    output logic              dbg_split_o
);

    localparam logic [5:0] OP_LOAD  = 6'b010000;
    localparam logic [5:0] OP_STORE = 6'b010001;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    state_e      state_q, state_d;

    logic [5:0]  u_op, l_op;
    logic        u_ld, u_st, l_ld, l_st, u_mem, l_mem, conflict;
    logic        issue_u, issue_l, sel_u, capture, zero_u, zero_l;

    logic [63:0] inst_d, inst_q;
    logic        l_rt_flag_d, l_rt_flag_q;
    logic [4:0]  u_rt_q, l_rt_q;
    logic [31:0] l_tdata_q;

    // Address bits above the BRAM depth are ignored by design.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{u_addr_from_exec[31:ADDR_W], l_addr_from_exec[31:ADDR_W]};

    assign u_op     = inst_from_exec[63:58];
    assign l_op     = inst_from_exec[31:26];
    assign u_ld     = (u_op == OP_LOAD);
    assign u_st     = (u_op == OP_STORE);
    assign l_ld     = (l_op == OP_LOAD);
    assign l_st     = (l_op == OP_STORE);
    assign u_mem    = u_ld | u_st;
    assign l_mem    = l_ld | l_st;
    assign conflict = u_mem && l_mem &&
                      (u_addr_from_exec[ADDR_W-1:0] != l_addr_from_exec[ADDR_W-1:0]);

    // State register; reset abandons any pending lower-lane half.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus which lanes issue this cycle; nothing happens in reset or interlock.
    always_comb begin
        state_d   = state_q;
        issue_u   = 1'b0;
        issue_l   = 1'b0;
        sel_u     = 1'b0;
        capture   = 1'b0;
        zero_u    = 1'b0;
        zero_l    = 1'b0;
        stall_req = 1'b0;
        if (rstn && !interlock) begin
            capture = 1'b1;
            case (state_q)
                IDLE: begin
                    if (conflict) begin
                        stall_req = 1'b1;
                        issue_u   = 1'b1;
                        sel_u     = 1'b1;
                        zero_l    = 1'b1;
                        state_d   = SPLIT;
                    end else begin
                        issue_u = u_mem;
                        issue_l = l_mem;
                        sel_u   = u_mem;
                    end
                end
                SPLIT: begin
                    issue_l = l_mem;
                    zero_u  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // BRAM port b: upper lane owns the high word half, lower lane the low half.
    always_comb begin
        mem_enb   = issue_u | issue_l;
        mem_addrb = '0;
        if (rstn) begin
            mem_addrb = sel_u ? u_addr_from_exec[ADDR_W-1:0] : l_addr_from_exec[ADDR_W-1:0];
        end
        mem_web   = {{4{issue_u && u_st}}, {4{issue_l && l_st}}};
        mem_dinb  = {(issue_u && u_st) ? u_sdata_from_exec : 32'h0,
                     (issue_l && l_st) ? l_sdata_from_exec : 32'h0};
    end

    // Writeback view of the bundle: a lane not issued this cycle has its opcode cleared.
    always_comb begin
        inst_d = inst_from_exec;
        if (zero_l) begin
            inst_d[31:26] = 6'b0;
        end
        if (zero_u) begin
            inst_d[63:58] = 6'b0;
        end
        l_rt_flag_d = l_rt_flag_from_exec && !l_ld && !zero_l;
    end

    // Writeback pipeline registers, held under interlock.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inst_q      <= '0;
            u_rt_q      <= '0;
            l_tdata_q   <= '0;
            l_rt_q      <= '0;
            l_rt_flag_q <= 1'b0;
        end else if (capture) begin
            inst_q      <= inst_d;
            u_rt_q      <= u_rt_from_exec;
            l_tdata_q   <= l_tdata_from_exec;
            l_rt_q      <= l_rt_from_exec;
            l_rt_flag_q <= l_rt_flag_d;
        end
    end

    assign inst_to_wb      = inst_q;
    assign u_rt_to_wb      = u_rt_q;
    assign u_rt_flag_to_wb = 1'b0;
    assign l_tdata_to_wb   = l_tdata_q;
    assign l_rt_to_wb      = l_rt_q;
    assign l_rt_flag_to_wb = l_rt_flag_q;
    assign dbg_split_o     = (state_q == SPLIT);

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] load_cnt_q, store_cnt_q, split_cnt_q;
    logic [1:0]  load_inc, store_inc;

    assign load_inc  = {1'b0, issue_u && u_ld} + {1'b0, issue_l && l_ld};
    assign store_inc = {1'b0, issue_u && u_st} + {1'b0, issue_l && l_st};

    function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Per-lane access and per-split counters; increments are zero while frozen.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            split_cnt_q <= '0;
        end else begin
            load_cnt_q  <= sat_add(load_cnt_q, load_inc);
            store_cnt_q <= sat_add(store_cnt_q, store_inc);
            split_cnt_q <= sat_add(split_cnt_q, {1'b0, stall_req});
        end
    end

    assign perf_load_cnt  = load_cnt_q;
    assign perf_store_cnt = store_cnt_q;
    assign perf_split_cnt = split_cnt_q;
`endif

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the dual-lane (upper/lower 32-bit) 64-bit-bundle pipeline.
- Sits between exec and writeback.
- Registers the exec bundle and drives BRAM port b (one-cycle read latency). Hands writeback the instruction, destination and lower-lane data in the same cycle that mem_doutb becomes valid.
- Splits bundles whose two lanes touch different memory words across two cycles, and requests a stall for the extra cycle.

Parameters:
- ADDR_W, 15, width of the 64-bit-word BRAM address.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- interlock  in  1  global freeze; holds all state and outputs
- inst_from_exec  in  64  bundle; upper op [63:58], lower op [31:26]
- u_addr_from_exec  in  32  upper effective address, 64-bit-word units
- u_sdata_from_exec  in  32  upper store data
- u_rt_from_exec  in  5  upper load destination
- l_addr_from_exec  in  32  lower effective address
- l_sdata_from_exec  in  32  lower store data
- l_tdata_from_exec  in  32  lower non-memory result to forward
- l_rt_from_exec  in  5  lower destination
- l_rt_flag_from_exec  in  1  lower writes rt (non-load)
- mem_addrb  out  ADDR_W  BRAM address
- mem_dinb  out  64  BRAM write data
- mem_web  out  8  byte write enables
- mem_enb  out  1  BRAM enable
- inst_to_wb  out  64  registered bundle; a suppressed lane's opcode field is 6'b0
- u_rt_to_wb  out  5  upper load destination
- u_rt_flag_to_wb  out  1  always 0; reserved
- l_tdata_to_wb  out  32  lower forwarded result
- l_rt_to_wb  out  5  lower destination
- l_rt_flag_to_wb  out  1  lower non-load write flag
- stall_req  out  1  exec must hold its bundle next cycle

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk.
  - While rstn=0, all registered outputs are 0, FSM goes to IDLE, mem_enb=0, mem_web=0.
  - Reset mid-split abandons the pending lower lane.
- Opcodes: LOAD=6'b010000, STORE=6'b010001. Any other opcode is non-memory.
- Lane data mapping:
  - The upper lane always uses word bits [63:32] and web[7:4].
  - The lower lane always uses word bits [31:0] and web[3:0].
  - mem_addrb = addr[ADDR_W-1:0]; higher address bits are ignored.
- Conflict: both lanes are memory ops and u_addr[ADDR_W-1:0] != l_addr[ADDR_W-1:0].
- Combined access (no conflict, same cycle):
  - mem_enb=1 if either lane is a memory op.
  - mem_addrb comes from the upper lane if it is a memory op, otherwise from the lower lane.
  - Each store lane sets its web half to 4'hF and places its data in its half of mem_dinb. An unused half of mem_dinb is 0.
  - Two stores to the same word merge: web=8'hFF.
- FSM:
  - IDLE, no conflict, interlock=0: issue the combined access; register the bundle into the *_to_wb outputs on the clock edge. stall_req=0.
  - IDLE, conflict, interlock=0: this cycle is the split's first half.
    - stall_req=1 (combinational).
    - Issue the upper lane only.
    - Register inst_to_wb with the lower opcode field zeroed and l_rt_flag_to_wb=0.
    - Go to SPLIT.
  - SPLIT, interlock=0: this cycle is the split's second half.
    - The held exec bundle is presented again. Issue the lower lane only.
    - Register inst_to_wb with the upper opcode field zeroed, plus the lower fields.
    - stall_req=0. Go to IDLE.
- interlock=1:
  - mem_enb=0 and mem_web=0, so mem_doutb holds its value.
  - Registers and FSM hold. stall_req=0.
- Latency: an access issued in cycle N has its inst_to_wb and mem_doutb valid in cycle N+1.
- A lower LOAD forces l_rt_flag_to_wb=0; writeback keys on the opcode instead.

Optional Feature:
- Macro: MEM_ACCESS_PERF_EN.
- When defined, three 32-bit saturating counters are added: load_cnt, store_cnt and split_cnt.
  - Each counts per lane access actually issued, or per split.
  - Counters are cleared by reset and frozen under interlock.
  - They are exposed as output ports perf_load_cnt, perf_store_cnt and perf_split_cnt.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: rstn=0 for 2 cycles with random inputs -> all outputs 0, mem_enb=0, stall_req=0.
- Single load: upper LOAD at addr 0x10, lower ADD with rt=3, tdata=0x55 -> next cycle:
  - mem_addrb was 0x10, web=0.
  - inst_to_wb upper op is LOAD.
  - l_rt_to_wb=3, l_tdata_to_wb=0x55, l_rt_flag_to_wb=1.
- Merged stores: upper STORE 0xAAAA0000 and lower STORE 0x1234 both to addr 0x20 -> web=8'hFF, mem_dinb=0xAAAA0000_00001234, no stall.
- Conflict: upper LOAD at 0x5, lower LOAD at 0x6 ->
  - Cycle 1: stall_req=1, mem_addrb=0x5, inst_to_wb lower op 0.
  - Cycle 2: mem_addrb=0x6, inst_to_wb upper op 0, FSM back to IDLE.
- Interlock during SPLIT: assert interlock for 3 cycles -> mem_enb=0 and outputs unchanged. After release, the lower lane issues exactly once.
- MEM_ACCESS_PERF_EN defined, previous four scenarios run -> load_cnt=3, store_cnt=2, split_cnt=1.
